iobus_button_capture: RTL
=========================

// Module: iobus_button_capture
// PURPOSE
//  Input-side IOBUS peripheral for the OTTER board: synchronizes and debounces raw
//  push-buttons, latches debounced press (rising) events, presents button level and
//  pending-event registers to the MCU over IOBUS reads, clears events on IOBUS write.
//  Sits between the board button pins and the wrapper's IOBUS_in mux; intr feeds MCU INTR.
// PARAMETERS
//  N_BTN            5             number of buttons (1..32)
//  DEBOUNCE_CYCLES  500000        consecutive stable cycles required (10 ms @ 50 MHz); >= 2
//  LEVEL_ADDR       32'h11008004  read: debounced level register
//  EVENT_ADDR       32'h11008008  read: pending press events; write: write-1-to-clear
// PORTS
//  clk          in   1      system clock (MCU clock domain)
//  reset_n      in   1      asynchronous, active-low reset
//  btn_raw      in   N_BTN  asynchronous raw button pins
//  iobus_addr   in   32     IOBUS address from MCU
//  iobus_wr     in   1      IOBUS write strobe, 1 cycle per write
//  iobus_out    in   32     IOBUS write data from MCU
//  iobus_rdata  out  32     read data for IOBUS_in mux (0 when not addressed)
//  iobus_hit    out  1      iobus_addr matches LEVEL_ADDR or EVENT_ADDR
//  btn_level    out  N_BTN  debounced button levels
//  intr         out  1      OR of all pending events
// BEHAVIOUR
//  - Reset (reset_n low, async): sync flops, stable levels, counters, pending all 0;
//    btn_level=0, intr=0; iobus_rdata/iobus_hit purely combinational from addr.
//  - Per bit: 2-FF synchronizer; sync[i] valid 2 edges after btn_raw[i] changes.
//  - Per bit counter, width $clog2(DEBOUNCE_CYCLES):
//      sync==stable                 -> cnt <= 0
//      sync!=stable, cnt<MAX        -> cnt <= cnt+1   (MAX = DEBOUNCE_CYCLES-1)
//      sync!=stable, cnt==MAX       -> stable <= sync, cnt <= 0
//    Any bounce back to stable level restarts count: a level must differ for
//    DEBOUNCE_CYCLES consecutive cycles. Raw-to-btn_level latency = 2+DEBOUNCE_CYCLES.
//  - Event: rise[i] = (cnt==MAX) & sync & ~stable; pending[i] sets on same edge stable
//    rises. Falling transitions never set pending.
//  - Write: iobus_wr & iobus_addr==EVENT_ADDR ->
//      pending <= (pending & ~iobus_out[N_BTN-1:0]) | rise  (set wins over clear).
//    Writes to LEVEL_ADDR or other addresses ignored; bits >= N_BTN ignored.
//  - Read (comb): LEVEL_ADDR -> zero-extended stable; EVENT_ADDR -> zero-extended
//    pending; else 32'b0. Reads have no side effects.
//  - intr = |pending (registered source, comb OR); drops the cycle after clearing write.
//  - Reset mid-debounce discards partial count; no event generated from reset release
//    unless button then held DEBOUNCE_CYCLES (+2) cycles.
// STRUCTURE
//  - otter_io_pkg: LEVEL/EVENT/LED/SEG/ANODE port address localparams, N_BTN default.
//  - Sub-module debounce_bit (synchronizer + counter + stable flop, outputs stable
//    and rise), instantiated N_BTN times via generate; top holds pending, bus decode.
// TESTING (sim with DEBOUNCE_CYCLES=4, N_BTN=5)
//  1. reset_n low -> btn_level=0, intr=0; read EVENT_ADDR/LEVEL_ADDR -> 0x0; other addr -> 0, hit=0.
//  2. btn_raw[0] 0->1 held -> btn_level[0]=1 exactly 6 edges later; intr=1; read EVENT_ADDR -> 0x1.
//  3. btn_raw[2] pulse of 3 cycles, then 0 -> btn_level/pending unchanged (0x0); counter restarts.
//  4. write 0x1 to EVENT_ADDR -> pending=0, intr=0 next cycle; write 0x2 on the edge bit1
//     rises -> pending[1]=1 (set wins); write 0x1 to LEVEL_ADDR -> no effect.
//  5. release btn 0 -> btn_level[0]=0 after 6 edges, pending unchanged, intr unchanged.
//  6. reset_n low after 3 cycles of bit3 high, release, hold bit3 -> rises 6 edges post-release only.

Source files
------------

// File: rtl/otter_io_pkg.sv
// Shared IOBUS port map and types for the OTTER board input/output peripherals.
// Address constants are the defaults; each peripheral can still override them by parameter.
package otter_io_pkg;

    localparam int          N_BTN_DEFAULT = 5;

    localparam logic [31:0] LEVEL_ADDR_DEFAULT = 32'h1100_8004;
    localparam logic [31:0] EVENT_ADDR_DEFAULT = 32'h1100_8008;
    localparam logic [31:0] LED_ADDR_DEFAULT   = 32'h1100_C000;
    localparam logic [31:0] SEG_ADDR_DEFAULT   = 32'h1100_C004;
    localparam logic [31:0] ANODE_ADDR_DEFAULT = 32'h1100_C008;

    typedef enum logic [1:0] {
        REG_NONE  = 2'd0,
        REG_LEVEL = 2'd1,
        REG_EVENT = 2'd2
    } btn_reg_e;

    // Level wins if the two addresses were ever configured identical.
    function automatic btn_reg_e decode_btn_reg(input logic [31:0] addr,
                                                input logic [31:0] level_addr,
                                                input logic [31:0] event_addr);
        if (addr == level_addr)      return REG_LEVEL;
        else if (addr == event_addr) return REG_EVENT;
        else                         return REG_NONE;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button channel: 2-FF synchronizer, consecutive-stable counter, debounced level.
// rise flags the cycle whose edge will move the debounced level from 0 to 1.
module debounce_bit
    import otter_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             at_max;

    assign at_max = (cnt == CNT_MAX);

    // NOTE: every flop here is reset, including the synchronizer, so a reset
    // mid-debounce discards all history and cannot fabricate a press event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            cnt       <= '0;
            stable    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the two synchronizer stages a real
            // shift register; blocking would collapse them into a single flop.
            sync_meta <= raw;
            sync      <= sync_meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (!at_max) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                stable <= sync;
                cnt    <= '0;
            end
        end
    end

    assign rise = at_max & sync & ~stable;

endmodule

// File: rtl/iobus_button_capture.sv
// IOBUS button peripheral: debounced levels, latched press events (write-1-to-clear),
// and an interrupt that stays high while any event is pending.
module iobus_button_capture
    import otter_io_pkg::*;
#(
    parameter int          N_BTN           = N_BTN_DEFAULT,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] LEVEL_ADDR      = LEVEL_ADDR_DEFAULT,
    parameter logic [31:0] EVENT_ADDR      = EVENT_ADDR_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [31:0]      iobus_addr,
    input  logic             iobus_wr,
    input  logic [31:0]      iobus_out,
    output logic [31:0]      iobus_rdata,
    output logic             iobus_hit,
    output logic [N_BTN-1:0] btn_level,
    output logic             intr
);

    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] clr_mask;
    logic             event_wr;
    logic             unused_iobus_out_hi;
    btn_reg_e         reg_sel;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (btn_raw[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    assign reg_sel  = decode_btn_reg(iobus_addr, LEVEL_ADDR, EVENT_ADDR);
    assign event_wr = iobus_wr && (reg_sel == REG_EVENT);
    assign clr_mask = event_wr ? iobus_out[N_BTN-1:0] : '0;

    // Write data above N_BTN has no meaning for this peripheral.
    assign unused_iobus_out_hi = ^iobus_out;

    // A press landing on the same edge as a clearing write stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | rise;
        end
    end

    // NOTE: iobus_rdata gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        iobus_rdata = 32'b0;
        case (reg_sel)
            REG_LEVEL: iobus_rdata = 32'(stable);
            REG_EVENT: iobus_rdata = 32'(pending);
            default:   iobus_rdata = 32'b0;
        endcase
    end

    assign iobus_hit = (reg_sel != REG_NONE);
    assign btn_level = stable;
    assign intr      = |pending;

endmodule
